// File: rtl/chimp_grid_drawer.sv
// Redraws the chimp game's tile grid into the shared VGA plotter.
// For each tile it reads one descriptor and paints a 16x16 block: blank, hidden, or a number.
//
// state  | meaning
// IDLE   | waiting for iStart
// FETCH  | oTileIdx presented; descriptor arrives next cycle
// DRAW   | 256 pixels of the current tile, one per cycle
// DONE   | one-cycle completion pulse; restarts if a redraw is pending
module chimp_grid_drawer #(
  parameter int COLS  = 8,
  parameter int ROWS  = 5,
  parameter int PITCH = 20,
  parameter int X0    = 2,
  parameter int Y0    = 10
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iStart,
  output logic [5:0] oTileIdx,
  input  logic [6:0] iTile,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       oBusy,
  output logic       oDone
);

  localparam int LAST = COLS * ROWS - 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAW, S_DONE} state_t;

  state_t     r_state, w_next;
  logic [3:0] r_px, r_py;
  logic [2:0] r_col, r_row;
  logic [5:0] r_tile;
  logic [6:0] r_desc;
  logic       r_pending;
  logic [7:0] r_x_hold;
  logic [6:0] r_y_hold;
  logic [2:0] r_c_hold;

  logic       w_first, w_last_px, w_last_tile, w_digit;
  logic [6:0] w_desc;
  logic [4:0] w_n;
  logic [3:0] w_tens, w_units;
  logic [2:0] w_gr, w_tens_row, w_units_row, w_colour;
  logic [7:0] w_x;
  logic [6:0] w_y;

  function automatic logic [2:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
    logic [14:0] g;
    case (d)
      4'd0:    g = 15'o75557;
      4'd1:    g = 15'o26227;
      4'd2:    g = 15'o71747;
      4'd3:    g = 15'o71717;
      4'd4:    g = 15'o55711;
      4'd5:    g = 15'o74717;
      4'd6:    g = 15'o74757;
      4'd7:    g = 15'o71111;
      4'd8:    g = 15'o75757;
      4'd9:    g = 15'o75717;
      default: g = '0;
    endcase
    case (r)
      3'd0:    return g[14:12];
      3'd1:    return g[11:9];
      3'd2:    return g[8:6];
      3'd3:    return g[5:3];
      3'd4:    return g[2:0];
      default: return 3'b000;
    endcase
  endfunction

  assign w_first     = (r_px == 4'd0) && (r_py == 4'd0);
  assign w_last_px   = (r_px == 4'd15) && (r_py == 4'd15);
  assign w_last_tile = (r_tile == 6'(LAST));
  // The descriptor is only guaranteed valid on the first DRAW cycle.
  assign w_desc      = w_first ? iTile : r_desc;
  assign w_n         = w_desc[4:0];
  assign w_tens      = 4'(w_n / 5'd10);
  assign w_units     = 4'(w_n % 5'd10);
  assign w_gr        = 3'((r_py - 4'd3) >> 1);
  assign w_tens_row  = glyph_row(w_tens, w_gr);
  assign w_units_row = glyph_row(w_units, w_gr);
  assign w_x         = 8'(X0) + 8'(r_col) * 8'(PITCH) + {4'd0, r_px};
  assign w_y         = 7'(Y0) + 7'(r_row) * 7'(PITCH) + {3'd0, r_py};

  always_comb begin
    w_digit  = 1'b0;
    w_colour = 3'b000;
    if (r_py >= 4'd3 && r_py <= 4'd12) begin
      if (r_px >= 4'd1 && r_px <= 4'd6 && w_n >= 5'd10)
        w_digit = w_tens_row[2'd2 - 2'((r_px - 4'd1) >> 1)];
      else if (r_px >= 4'd9 && r_px <= 4'd14)
        w_digit = w_units_row[2'd2 - 2'((r_px - 4'd9) >> 1)];
    end
    if (!w_desc[6])      w_colour = 3'b000;
    else if (!w_desc[5]) w_colour = 3'b111;
    else                 w_colour = w_digit ? 3'b111 : 3'b001;
  end

  always_comb begin
    w_next = r_state;
    oPlot  = 1'b0;
    oBusy  = 1'b0;
    oDone  = 1'b0;
    case (r_state)
      S_IDLE:  if (iStart) w_next = S_FETCH;
      S_FETCH: begin
        oBusy  = 1'b1;
        w_next = S_DRAW;
      end
      S_DRAW: begin
        oBusy = 1'b1;
        oPlot = 1'b1;
        if (w_last_px) w_next = w_last_tile ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        oDone  = 1'b1;
        w_next = (r_pending || iStart) ? S_FETCH : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      r_px      <= '0;
      r_py      <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_tile    <= '0;
      r_desc    <= '0;
      r_pending <= 1'b0;
      r_x_hold  <= '0;
      r_y_hold  <= '0;
      r_c_hold  <= '0;
    end else begin
      if (r_state == S_DONE)
        r_pending <= 1'b0;
      else if (iStart && r_state != S_IDLE)
        r_pending <= 1'b1;

      if (r_state == S_DRAW) begin
        r_x_hold <= w_x;
        r_y_hold <= w_y;
        r_c_hold <= w_colour;
        if (w_first) r_desc <= iTile;
        r_px <= r_px + 4'd1;
        if (r_px == 4'd15) r_py <= r_py + 4'd1;
        if (w_last_px && !w_last_tile) begin
          r_tile <= r_tile + 6'd1;
          if (r_col == 3'(COLS - 1)) begin
            r_col <= '0;
            r_row <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
      end else if (w_next == S_FETCH) begin
        r_tile <= '0;
        r_col  <= '0;
        r_row  <= '0;
        r_px   <= '0;
        r_py   <= '0;
      end
    end
  end

  assign oTileIdx = r_tile;
  assign oX       = (r_state == S_DRAW) ? w_x : r_x_hold;
  assign oY       = (r_state == S_DRAW) ? w_y : r_y_hold;
  assign oColour  = (r_state == S_DRAW) ? w_colour : r_c_hold;

endmodule

// File: tb/tb_chimp_grid_drawer.sv
// Self-checking bench for chimp_grid_drawer: every plotted pixel is compared against a
// reference computed from tile position, digit split and the 3x5 font.
module tb_chimp_grid_drawer;

  logic       clk = 1'b0;
  logic       iReset, iStart;
  logic [5:0] oTileIdx;
  logic [6:0] iTile;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot, oBusy, oDone;

  chimp_grid_drawer dut (
    .clk(clk), .iReset(iReset), .iStart(iStart), .oTileIdx(oTileIdx), .iTile(iTile),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;
  int prints     = 0;
  int cyc        = 0;
  logic [6:0] mem [64];
  int font [10][5] = '{'{7,5,5,5,7}, '{2,6,2,2,7}, '{7,1,7,4,7}, '{7,1,7,1,7}, '{5,5,7,1,1},
                       '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,1,1,1}, '{7,5,7,5,7}, '{7,5,7,1,7}};

  int mon_k, plot_cnt, nonzero_cnt, done_cnt, gap, first_fetch, last_done;
  int cap_x [10240];
  int cap_y [10240];
  int cap_c [10240];
  logic hold_tile = 1'b0;

  typedef struct {
    int tile; int px; int py; int ex; int ey; int ec;
  } vec_t;
  vec_t vecs [11];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int font_bit(input int d, input int row, input int col);
    return (font[d][row] >> (2 - col)) & 1;
  endfunction

  function automatic int mdl_colour(input logic [6:0] d, input int px, input int py);
    int n, on;
    if (!d[6]) return 0;
    if (!d[5]) return 7;
    n  = int'(d[4:0]);
    on = 0;
    if (py >= 3 && py <= 12) begin
      if (px >= 1 && px <= 6 && n >= 10) on = font_bit(n / 10, (py - 3) / 2, (px - 1) / 2);
      if (px >= 9 && px <= 14)           on = font_bit(n % 10, (py - 3) / 2, (px - 9) / 2);
    end
    return on ? 7 : 1;
  endfunction

  // Descriptor source: valid from the FETCH cycle through the first DRAW cycle, garbage after.
  always @(negedge clk) begin
    if (oBusy && !oPlot) begin
      iTile     = mem[oTileIdx];
      hold_tile = 1'b1;
    end else if (hold_tile) begin
      hold_tile = 1'b0;
    end else begin
      iTile = 7'($urandom);
    end
  end

  always @(negedge clk) begin
    if (!iReset) begin
      if (oBusy && !oPlot && first_fetch < 0) first_fetch = cyc;
      if (oPlot) begin
        int t, px, py, ex, ey, ec;
        t  = mon_k / 256;
        px = (mon_k % 256) % 16;
        py = (mon_k % 256) / 16;
        ex = 2 + (t % 8) * 20 + px;
        ey = 10 + (t / 8) * 20 + py;
        ec = (t < 40) ? mdl_colour(mem[t], px, py) : -1;
        assertions++;
        if (int'(oX) != ex || int'(oY) != ey || int'(oColour) != ec) begin
          failures++;
          if (prints < 20)
            $display("FAIL pixel k=%0d: actual=(%0d,%0d,c%0d) required=(%0d,%0d,c%0d)",
                     mon_k, oX, oY, oColour, ex, ey, ec);
          prints++;
        end
        if (mon_k < 10240) begin
          cap_x[mon_k] = int'(oX);
          cap_y[mon_k] = int'(oY);
          cap_c[mon_k] = int'(oColour);
        end
        plot_cnt++;
        if (oColour != 3'b000) nonzero_cnt++;
        mon_k++;
      end
      if (oDone) begin
        done_cnt++;
        last_done = cyc;
        mon_k     = 0;
      end
      if (done_cnt == 1 && !oBusy) gap++;
    end
  end

  task automatic clear_counts();
    mon_k = 0; plot_cnt = 0; nonzero_cnt = 0; done_cnt = 0; gap = 0;
    first_fetch = -1; last_done = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 iStart = 1'b1;
    @(posedge clk); #1 iStart = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt < target) chk("timeout_waiting_done", done_cnt, target);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 64; i++) mem[i] = 7'($urandom);
  endtask

  initial begin
    iReset = 1'b1; iStart = 1'b0; iTile = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    clear_counts();
    vecs[0]  = '{0, 1, 3, 3, 13, 1};
    vecs[1]  = '{0, 9, 3, 11, 13, 7};
    vecs[2]  = '{0, 11, 5, 13, 15, 1};
    vecs[3]  = '{0, 13, 12, 15, 22, 7};
    vecs[4]  = '{0, 0, 0, 2, 10, 1};
    vecs[5]  = '{9, 0, 0, 22, 30, 7};
    vecs[6]  = '{9, 15, 15, 37, 45, 7};
    vecs[7]  = '{39, 1, 3, 143, 93, 7};
    vecs[8]  = '{39, 1, 5, 143, 95, 1};
    vecs[9]  = '{39, 11, 3, 153, 93, 7};
    vecs[10] = '{39, 9, 3, 151, 93, 1};
    repeat (3) @(posedge clk);
    @(negedge clk) iReset = 1'b0;
    #1;
    chk("reset_oPlot", oPlot, 0);
    chk("reset_oBusy", oBusy, 0);
    chk("reset_oDone", oDone, 0);
    chk("reset_oTileIdx", oTileIdx, 0);
    chk("reset_oXYC", {oX, oY, oColour}, 0);

    // All descriptors zero: full erase pass and timing.
    clear_counts();
    @(posedge clk); #1 iStart = 1'b1;
    chk("busy_before_start_sampled", oBusy, 0);
    @(posedge clk); #1 iStart = 1'b0;
    chk("busy_after_start_sampled", oBusy, 1);
    wait_dones(1, 12000);
    repeat (5) @(negedge clk);
    #1;
    chk("erase_plot_count", plot_cnt, 10240);
    chk("erase_nonzero_colours", nonzero_cnt, 0);
    chk("erase_done_count", done_cnt, 1);
    chk("erase_done_latency", last_done - first_fetch, 10280);
    chk("hold_x", oX, 157);
    chk("hold_y", oY, 105);

    // Random grid with the documented corner tiles.
    randomize_mem();
    mem[0]  = 7'b1100111;
    mem[9]  = 7'b1011111;
    mem[39] = 7'b1111111;
    clear_counts();
    pulse_start();
    wait_dones(1, 12000);
    repeat (3) @(negedge clk);
    #1;
    chk("grid_plot_count", plot_cnt, 10240);
    chk("grid_done_count", done_cnt, 1);
    for (int i = 0; i < 11; i++) begin
      int k;
      k = vecs[i].tile * 256 + vecs[i].py * 16 + vecs[i].px;
      chk($sformatf("vec%0d_x", i), cap_x[k], vecs[i].ex);
      chk($sformatf("vec%0d_y", i), cap_y[k], vecs[i].ey);
      chk($sformatf("vec%0d_colour", i), cap_c[k], vecs[i].ec);
    end
    begin
      int hid = 0;
      for (int k = 9 * 256; k < 10 * 256; k++) if (cap_c[k] == 7) hid++;
      chk("hidden_tile9_all_white", hid, 256);
    end
    chk("hold_colour", oColour, mdl_colour(mem[39], 15, 15));

    // Two extra starts during a redraw collapse into one more redraw.
    randomize_mem();
    clear_counts();
    pulse_start();
    repeat (1000) @(negedge clk);
    pulse_start();
    repeat (3000) @(negedge clk);
    pulse_start();
    wait_dones(2, 25000);
    chk("pending_done_count", done_cnt, 2);
    chk("pending_busy_gap", gap, 1);
    repeat (300) @(negedge clk);
    #1;
    chk("pending_no_third", done_cnt, 2);
    chk("pending_plot_count", plot_cnt, 20480);
    chk("pending_idle_busy", oBusy, 0);

    // Asynchronous reset in the middle of tile 3.
    clear_counts();
    pulse_start();
    begin
      int n = 0;
      while (plot_cnt < 3 * 256 + 101 && n < 2000) begin
        @(negedge clk); #1;
        n++;
      end
    end
    chk("midreset_reached", plot_cnt, 3 * 256 + 101);
    iReset = 1'b1;
    #1;
    chk("midreset_oPlot", oPlot, 0);
    chk("midreset_oBusy", oBusy, 0);
    chk("midreset_oDone", oDone, 0);
    chk("midreset_oTileIdx", oTileIdx, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) iReset = 1'b0;
    clear_counts();
    repeat (500) @(negedge clk);
    #1;
    chk("midreset_no_plots", plot_cnt, 0);
    chk("midreset_idle_busy", oBusy, 0);
    pulse_start();
    wait_dones(1, 12000);
    chk("post_reset_plot_count", plot_cnt, 10240);
    chk("post_reset_done_count", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
